ex_muldiv_unit: RTL and testbench

//  Iterative multiply/divide unit in the EX stage. Consumes operand A (rs) and the

---
 rtl/ex_muldiv_unit.sv | 248 ++++++++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// ---------------------------------------------------------------------------
// ex_muldiv_unit
//
// Iterative multiply/divide unit for the EX stage. Runs MULTU/MULT/DIVU/DIV
// on a radix-2 datapath, one bit per cycle for NBITS cycles, and keeps the
// results in the architectural HI/LO registers. MTHI/MTLO write those
// registers directly while the unit is idle. Busy goes to the hazard unit so
// it can stall MFHI/MFLO and any new mul/div until the result is available.
//
// Ports
//   i_clk      clock, rising-edge
//   i_rst_n    asynchronous active-low reset
//   i_start    start request, sampled only in IDLE
//   i_op       00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   i_opA      multiplicand / dividend (rs); also MTHI/MTLO data
//   i_opB      multiplier / divisor
//   i_flush    abort the operation in flight
//   i_hi_we    MTHI write enable (IDLE only)
//   i_lo_we    MTLO write enable (IDLE only)
//   o_busy     high in BUSY and DONE
//   o_done     one-cycle completion pulse; o_hi/o_lo carry the result then
//   o_hi       HI register
//   o_lo       LO register
// ---------------------------------------------------------------------------
module ex_muldiv_unit #(
    parameter int NBITS = 32,
    parameter int CNTW  = 6
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [NBITS-1:0] i_opA,
    input  logic [NBITS-1:0] i_opB,
    input  logic             i_flush,
    input  logic             i_hi_we,
    input  logic             i_lo_we,
    output logic             o_busy,
    output logic             o_done,
    output logic [NBITS-1:0] o_hi,
    output logic [NBITS-1:0] o_lo
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [NBITS-1:0]   ONE_N    = NBITS'(1);
    localparam logic [2*NBITS-1:0] ONE_2N   = (2*NBITS)'(1);
    localparam logic [CNTW-1:0]    CNT_LAST = CNTW'(NBITS - 1);
    localparam logic [CNTW-1:0]    CNT_ONE  = CNTW'(1);

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [NBITS-1:0]   opb_q, opb_d;         // |B|
    logic [NBITS-1:0]   dvd_raw_q, dvd_raw_d; // A as given, for divide-by-zero HI
    logic               neg_res_q, neg_res_d; // product / quotient sign
    logic               neg_rem_q, neg_rem_d; // remainder sign (dividend sign)
    logic [NBITS-1:0]   acc_hi_q, acc_hi_d;   // product high half / remainder
    logic [NBITS-1:0]   acc_lo_q, acc_lo_d;   // multiplier-product low / dividend-quotient
    logic [CNTW-1:0]    cnt_q, cnt_d;
    logic [NBITS-1:0]   hi_q, hi_d;
    logic [NBITS-1:0]   lo_q, lo_d;

    // ---------------------------------------------------------------------
    // Operand conditioning at start: signed ops work on magnitudes and
    // remember the signs for the final correction.
    // ---------------------------------------------------------------------
    logic             a_neg, b_neg;
    logic [NBITS-1:0] a_mag, b_mag;

    always_comb begin
        a_neg = i_op[0] & i_opA[NBITS-1];
        b_neg = i_op[0] & i_opB[NBITS-1];
        a_mag = a_neg ? (~i_opA + ONE_N) : i_opA;
        b_mag = b_neg ? (~i_opB + ONE_N) : i_opB;
    end

    // ---------------------------------------------------------------------
    // Multiply step: acc_lo holds the remaining multiplier bits; each cycle
    // the multiplicand is conditionally added into the high half and the
    // whole {hi,lo} pair shifts right by one.
    // ---------------------------------------------------------------------
    logic [NBITS:0]   mul_sum;
    logic [NBITS-1:0] mul_hi_nxt, mul_lo_nxt;

    always_comb begin
        mul_sum    = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : {(NBITS+1){1'b0}});
        mul_hi_nxt = mul_sum[NBITS:1];
        mul_lo_nxt = {mul_sum[0], acc_lo_q[NBITS-1:1]};
    end

    // ---------------------------------------------------------------------
    // Restoring divide step: shift the next dividend bit into the partial
    // remainder, subtract the divisor when it fits, shift the quotient bit
    // in at the bottom of acc_lo. The partial remainder is always below the
    // divisor, so the trial value needs one extra bit and the difference
    // always fits back into NBITS.
    // ---------------------------------------------------------------------
    logic [NBITS:0]   div_shift;
    logic             div_ok;
    logic [NBITS-1:0] div_sub;
    logic [NBITS-1:0] div_hi_nxt, div_lo_nxt;

    always_comb begin
        div_shift  = {acc_hi_q, acc_lo_q[NBITS-1]};
        div_ok     = (div_shift >= {1'b0, opb_q});
        div_sub    = div_shift[NBITS-1:0] - opb_q;
        div_hi_nxt = div_ok ? div_sub : div_shift[NBITS-1:0];
        div_lo_nxt = {acc_lo_q[NBITS-2:0], div_ok};
    end

    // ---------------------------------------------------------------------
    // Final result with sign correction, valid while in DONE.
    // Divide by zero bypasses correction: LO all ones, HI = original A.
    // The most-negative / -1 case needs no special handling: the magnitude
    // quotient 2**(NBITS-1) is already the right bit pattern.
    // ---------------------------------------------------------------------
    logic [2*NBITS-1:0] prod, prod_neg;
    logic [NBITS-1:0]   res_hi, res_lo;

    always_comb begin
        prod     = {acc_hi_q, acc_lo_q};
        prod_neg = ~prod + ONE_2N;
        res_hi   = acc_hi_q;
        res_lo   = acc_lo_q;
        if (!op_q[1]) begin
            if (neg_res_q) begin
                res_hi = prod_neg[2*NBITS-1:NBITS];
                res_lo = prod_neg[NBITS-1:0];
            end
        end else if (opb_q == '0) begin
            res_hi = dvd_raw_q;
            res_lo = '1;
        end else begin
            if (neg_res_q) res_lo = ~acc_lo_q + ONE_N;
            if (neg_rem_q) res_hi = ~acc_hi_q + ONE_N;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        opb_d     = opb_q;
        dvd_raw_d = dvd_raw_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        unique case (state_q)
            ST_IDLE: begin
                // A same-cycle MTHI/MTLO still lands; a started op overwrites it at DONE.
                if (i_hi_we) hi_d = i_opA;
                if (i_lo_we) lo_d = i_opA;
                if (i_start && !i_flush) begin
                    state_d   = ST_BUSY;
                    op_d      = i_op;
                    opb_d     = b_mag;
                    dvd_raw_d = i_opA;
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    acc_hi_d  = '0;
                    acc_lo_d  = a_mag;
                    cnt_d     = '0;
                end
            end
            ST_BUSY: begin
                if (i_flush) begin
                    state_d = ST_IDLE;
                end else begin
                    if (op_q[1]) begin
                        acc_hi_d = div_hi_nxt;
                        acc_lo_d = div_lo_nxt;
                    end else begin
                        acc_hi_d = mul_hi_nxt;
                        acc_lo_d = mul_lo_nxt;
                    end
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (!i_flush) begin
                    hi_d = res_hi;
                    lo_d = res_lo;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            opb_q     <= '0;
            dvd_raw_q <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            opb_q     <= opb_d;
            dvd_raw_q <= dvd_raw_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs. In the DONE cycle HI/LO are shown straight from the
    // correction logic so the result is visible alongside o_done; a flush
    // in that cycle suppresses both the pulse and the result.
    // ---------------------------------------------------------------------
    always_comb begin
        o_busy = (state_q != ST_IDLE);
        o_done = (state_q == ST_DONE) && !i_flush;
        o_hi   = o_done ? res_hi : hi_q;
        o_lo   = o_done ? res_lo : lo_q;
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_ex_muldiv_unit
//
// Directed testbench for ex_muldiv_unit (NBITS=32). Inputs are driven on the
// falling edge, outputs sampled on the falling edge. Negedge n_j after the
// start edge lies in cycle k+j, so o_done is expected at j = 33.
// ---------------------------------------------------------------------------
module tb_ex_muldiv_unit;

    localparam int NBITS = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [1:0]       op;
    logic [NBITS-1:0] opa, opb;
    logic             flush, hi_we, lo_we;
    logic             busy, done;
    logic [NBITS-1:0] hi, lo;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    ex_muldiv_unit #(.NBITS(NBITS), .CNTW(6)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (start),
        .i_op    (op),
        .i_opA   (opa),
        .i_opB   (opb),
        .i_flush (flush),
        .i_hi_we (hi_we),
        .i_lo_we (lo_we),
        .o_busy  (busy),
        .o_done  (done),
        .o_hi    (hi),
        .o_lo    (lo)
    );

    // Stimulus driver only: issues one op and returns what o_hi/o_lo showed in
    // the o_done cycle plus the observed latency (-1 when o_done never came).
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] rh, output logic [31:0] rl, output int lat);
        @(negedge clk);
        op = o; opa = a; opb = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = -1; rh = '0; rl = '0;
        for (int j = 1; j <= 60; j++) begin
            if (done === 1'b1) begin
                rh = hi; rl = lo; lat = j;
                break;
            end
            @(negedge clk);
        end
        $display("op=%0d a=%08h b=%08h -> hi=%08h lo=%08h latency=%0d", o, a, b, rh, rl, lat);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; op = '0; opa = '0; opb = '0;
        flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        #1;
        total_cnt++;
        if ({busy, done, hi, lo} !== {2'b00, 64'h0}) begin
            $display("FAIL reset_state busy=%b done=%b hi=%08h lo=%08h expected 0/0/0/0", busy, done, hi, lo);
        end else pass_cnt++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_release_busy got %b expected 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_multu();
        logic [31:0] rh, rl;
        int lat;
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, rh, rl, lat);
        total_cnt++;
        if ({rh, rl} !== 64'hFFFF_FFFE_0000_0001)
            $display("FAIL multu_max got %08h_%08h expected fffffffe_00000001", rh, rl);
        else pass_cnt++;
        total_cnt++;
        if (lat !== 33) $display("FAIL multu_latency got %0d expected 33", lat);
        else pass_cnt++;
        total_cnt++;
        if ({busy, hi, lo} !== {1'b0, 64'hFFFF_FFFE_0000_0001})
            $display("FAIL multu_hold busy=%b hi=%08h lo=%08h expected 0 fffffffe 00000001", busy, hi, lo);
        else pass_cnt++;
    endtask

    task automatic test_busy_window();
        int busy_cycles;
        @(negedge clk);
        op = 2'b00; opa = 32'd3; opb = 32'd4; start = 1'b1;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL busy_before_start got %b expected 0", busy);
        else pass_cnt++;
        @(negedge clk);
        start = 1'b0;
        busy_cycles = 0;
        for (int j = 1; j <= 40; j++) begin
            if (busy === 1'b1) busy_cycles++;
            @(negedge clk);
        end
        total_cnt++;
        if (busy_cycles !== 33) $display("FAIL busy_window got %0d cycles expected 33", busy_cycles);
        else pass_cnt++;
    endtask

    task automatic test_mult();
        logic [31:0] va [2] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD};
        logic [31:0] vb [2] = '{32'd7, 32'hFFFF_FFFC};
        logic [63:0] ve [2] = '{64'hFFFF_FFFF_FFFF_FFEB, 64'h0000_0000_0000_000C};
        logic [31:0] rh, rl;
        int lat;
        for (int i = 0; i < 2; i++) begin
            run_op(2'b01, va[i], vb[i], rh, rl, lat);
            total_cnt++;
            if ({rh, rl} !== ve[i])
                $display("FAIL mult_%0d got %08h_%08h expected %016h", i, rh, rl, ve[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_div();
        // -7/2 = -3 r -1 ; 7/-2 = -3 r 1 ; 100/7 unsigned = 14 r 2
        logic [1:0]  vo [3] = '{2'b11, 2'b11, 2'b10};
        logic [31:0] va [3] = '{32'hFFFF_FFF9, 32'd7, 32'd100};
        logic [31:0] vb [3] = '{32'd2, 32'hFFFF_FFFE, 32'd7};
        logic [31:0] eh [3] = '{32'hFFFF_FFFF, 32'd1, 32'd2};
        logic [31:0] el [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd14};
        logic [31:0] rh, rl;
        int lat;
        for (int i = 0; i < 3; i++) begin
            run_op(vo[i], va[i], vb[i], rh, rl, lat);
            total_cnt++;
            if (rl !== el[i] || rh !== eh[i])
                $display("FAIL div_%0d got lo=%08h hi=%08h expected lo=%08h hi=%08h", i, rl, rh, el[i], eh[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_div_boundaries();
        // DIVU /0, DIV /0 (no sign correction), most-negative / -1
        logic [1:0]  vo [3] = '{2'b10, 2'b11, 2'b11};
        logic [31:0] va [3] = '{32'h0000_1234, 32'hFFFF_FFFB, 32'h8000_0000};
        logic [31:0] vb [3] = '{32'd0, 32'd0, 32'hFFFF_FFFF};
        logic [31:0] eh [3] = '{32'h0000_1234, 32'hFFFF_FFFB, 32'h0};
        logic [31:0] el [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [31:0] rh, rl;
        int lat;
        for (int i = 0; i < 3; i++) begin
            run_op(vo[i], va[i], vb[i], rh, rl, lat);
            total_cnt++;
            if (rl !== el[i] || rh !== eh[i] || lat !== 33)
                $display("FAIL divbound_%0d got lo=%08h hi=%08h lat=%0d expected lo=%08h hi=%08h lat=33",
                         i, rl, rh, lat, el[i], eh[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [31:0] rh, rl;
        @(negedge clk);
        op = 2'b00; opa = 32'd5; opb = 32'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = -1; rh = '0; rl = '0;
        for (int j = 1; j <= 60; j++) begin
            if (j == 10) begin
                op = 2'b00; opa = 32'd9; opb = 32'd9; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                rh = hi; rl = lo; lat = j;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        $display("op=0 a=5 b=6 (restart at cycle 10) -> hi=%08h lo=%08h latency=%0d", rh, rl, lat);
        total_cnt++;
        if (rh !== 32'd0 || rl !== 32'd30 || lat !== 33)
            $display("FAIL start_while_busy got hi=%08h lo=%08h lat=%0d expected 0 1e 33", rh, rl, lat);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL no_restart busy=%b expected 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_flush_busy();
        logic seen_done;
        @(negedge clk);
        op = 2'b00; opa = 32'd7; opb = 32'd8; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL flush_busy_idle busy=%b expected 0", busy);
        else pass_cnt++;
        seen_done = 1'b0;
        for (int j = 0; j < 40; j++) begin
            if (done === 1'b1) seen_done = 1'b1;
            @(negedge clk);
        end
        $display("flush in BUSY -> hi=%08h lo=%08h", hi, lo);
        total_cnt++;
        if (seen_done !== 1'b0 || hi !== 32'd0 || lo !== 32'd30)
            $display("FAIL flush_busy_result done_seen=%b hi=%08h lo=%08h expected 0 0 1e", seen_done, hi, lo);
        else pass_cnt++;
    endtask

    task automatic test_flush_done();
        @(negedge clk);
        op = 2'b10; opa = 32'd100; opb = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (32) @(negedge clk);
        total_cnt++;
        if (done !== 1'b1 || lo !== 32'd14)
            $display("FAIL done_cycle_view done=%b lo=%08h expected 1 0000000e", done, lo);
        else pass_cnt++;
        flush = 1'b1;
        #1;
        total_cnt++;
        if (done !== 1'b0 || lo !== 32'd30)
            $display("FAIL flush_done_pulse done=%b lo=%08h expected 0 0000001e", done, lo);
        else pass_cnt++;
        @(negedge clk);
        flush = 1'b0;
        $display("flush in DONE -> hi=%08h lo=%08h busy=%b", hi, lo, busy);
        total_cnt++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd30)
            $display("FAIL flush_done_discard busy=%b hi=%08h lo=%08h expected 0 0 1e", busy, hi, lo);
        else pass_cnt++;
    endtask

    task automatic test_flush_idle();
        logic seen_busy;
        @(negedge clk);
        op = 2'b00; opa = 32'd2; opb = 32'd2; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        seen_busy = 1'b0;
        for (int j = 0; j < 40; j++) begin
            if (busy === 1'b1 || done === 1'b1) seen_busy = 1'b1;
            @(negedge clk);
        end
        $display("start+flush in IDLE -> busy_seen=%b lo=%08h", seen_busy, lo);
        total_cnt++;
        if (seen_busy !== 1'b0 || lo !== 32'd30)
            $display("FAIL flush_blocks_start busy_seen=%b lo=%08h expected 0 0000001e", seen_busy, lo);
        else pass_cnt++;
    endtask

    task automatic test_mthi_mtlo();
        logic [31:0] rh, rl;
        int lat;
        @(negedge clk);
        opa = 32'h0000_AAAA; hi_we = 1'b1;
        total_cnt++;
        if (hi !== 32'd0) $display("FAIL mthi_before_edge hi=%08h expected 00000000", hi);
        else pass_cnt++;
        @(negedge clk);
        hi_we = 1'b0; opa = 32'h0000_5555; lo_we = 1'b1;
        total_cnt++;
        if (hi !== 32'h0000_AAAA) $display("FAIL mthi hi=%08h expected 0000aaaa", hi);
        else pass_cnt++;
        @(negedge clk);
        lo_we = 1'b0;
        $display("MTHI/MTLO -> hi=%08h lo=%08h", hi, lo);
        total_cnt++;
        if (lo !== 32'h0000_5555 || hi !== 32'h0000_AAAA)
            $display("FAIL mtlo lo=%08h hi=%08h expected 00005555 0000aaaa", lo, hi);
        else pass_cnt++;
        // MTLO while busy is ignored
        @(negedge clk);
        op = 2'b00; opa = 32'd2; opb = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        opa = 32'h0000_0777; lo_we = 1'b1;
        @(negedge clk);
        lo_we = 1'b0;
        total_cnt++;
        if (lo !== 32'h0000_5555) $display("FAIL mtlo_busy lo=%08h expected 00005555", lo);
        else pass_cnt++;
        repeat (40) @(negedge clk);
        total_cnt++;
        if (hi !== 32'd0 || lo !== 32'd6)
            $display("FAIL mtlo_busy_result hi=%08h lo=%08h expected 0 6", hi, lo);
        else pass_cnt++;
        // MTHI in the same cycle as start: write lands, result overwrites later
        @(negedge clk);
        op = 2'b00; opa = 32'h0000_1234; opb = 32'd2; start = 1'b1; hi_we = 1'b1;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0;
        total_cnt++;
        if (hi !== 32'h0000_1234) $display("FAIL mthi_with_start hi=%08h expected 00001234", hi);
        else pass_cnt++;
        repeat (40) @(negedge clk);
        total_cnt++;
        if (hi !== 32'd0 || lo !== 32'h0000_2468)
            $display("FAIL mthi_with_start_result hi=%08h lo=%08h expected 0 00002468", hi, lo);
        else pass_cnt++;
        run_op(2'b00, 32'd1, 32'd1, rh, rl, lat);
    endtask

    task automatic test_reset_midop();
        @(negedge clk);
        opa = 32'h0000_AAAA; hi_we = 1'b1;
        @(negedge clk);
        hi_we = 1'b0;
        op = 2'b00; opa = 32'd5; opb = 32'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        total_cnt++;
        if (busy !== 1'b1 || hi !== 32'h0000_AAAA || lo !== 32'd1)
            $display("FAIL pre_reset busy=%b hi=%08h lo=%08h expected 1 0000aaaa 1", busy, hi, lo);
        else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        $display("reset mid-op -> busy=%b hi=%08h lo=%08h", busy, hi, lo);
        total_cnt++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0)
            $display("FAIL reset_midop busy=%b hi=%08h lo=%08h expected 0 0 0", busy, hi, lo);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        total_cnt++;
        if (busy !== 1'b0 || lo !== 32'd0)
            $display("FAIL post_reset busy=%b lo=%08h expected 0 0", busy, lo);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_multu();
        test_busy_window();
        test_mult();
        test_div();
        test_div_boundaries();
        test_back_to_back();
        test_flush_busy();
        test_flush_done();
        test_flush_idle();
        test_mthi_mtlo();
        test_reset_midop();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
